mips_cpu_alu_arbiter: RTL and testbench
=======================================

MIPS_CPU_ALU_ARBITER -- requirements
Module: mips_cpu_alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin arbitration; 0 = fixed priority, port 0 wins.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_ready  output  1  operation accepted this cycle when reqN_valid also high.
REQ-006 reqN_op  input  5  ALU opcode (0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLLV, 10 SRLV, 11 SRAV).
REQ-007 reqN_a, reqN_b  input  32 each  operands.
REQ-008 reqN_sa  input  5  shift amount.
REQ-009 rspN_valid  output  1  result for requester N available.
REQ-010 rspN_ready  input  1  requester N consumes the result.
REQ-011 rspN_result  output  32  captured ALU result.
REQ-012 rspN_zero  output  1  captured ALU zero flag.
REQ-013 rspN_err  output  1  opcode was outside 0..11.
REQ-014 alu_op, alu_a, alu_b, alu_sa  output  5/32/32/5  drive to the shared ALU instance.
REQ-015 alu_result, alu_zero  input  32/1  from the shared ALU instance.

Function
REQ-016 FSM states IDLE, EXEC, RESP; only IDLE accepts requests.
REQ-017 In IDLE, at most one reqN_ready SHALL be high, asserted only for the arbitration winner among valid ports; both low when no valid.
REQ-018 Arbitration: single valid port wins; both valid with RR_EN=1 -> port other than last_grant wins; RR_EN=0 -> port 0 wins.
REQ-019 last_grant SHALL update only on an accepted handshake.
REQ-020 Accept (valid & ready in IDLE, cycle T): latch op, a, b, sa and owner id; go to EXEC at T+1.
REQ-021 alu_op/alu_a/alu_b/alu_sa SHALL always drive the latched registers (stable through EXEC and RESP).
REQ-022 EXEC (T+1): capture alu_result and alu_zero at end of cycle; go to RESP.
REQ-023 Latched op > 11: err flag set; captured result forced to 0 and zero forced to 1, regardless of ALU outputs.
REQ-024 RESP (from T+2): rspN_valid high for owner only; result/zero/err held stable until rspN_ready.
REQ-025 rspN_valid & rspN_ready -> IDLE next cycle; new accept earliest that IDLE cycle (max throughput 1 op / 3 cycles).
REQ-026 rspN_ready while rspN_valid low SHALL be ignored; non-owner rsp outputs SHALL be result 0, zero 0, err 0.
REQ-027 Request input changes during EXEC/RESP SHALL not affect in-flight operation.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, all reqN_ready and rspN_valid low, latched operands/op/sa 0, captured result 0, zero 0, err 0, last_grant = 1 (port 0 wins first tie).
REQ-029 Reset mid-EXEC or mid-RESP SHALL discard the in-flight operation; no response after release.
REQ-030 First accept possible on the first rising edge with rst_n high.

Verification
REQ-031 Single op: req0 op=2, a=5, b=7 -> req0_ready same cycle; rsp0_valid 2 cycles later, result 12, zero 0, err 0.
REQ-032 Tie RR_EN=1 after reset: both valid (req0 op=3 a=b=9, req1 op=0) -> port 0 first (result 0, zero 1); port 1 granted on next IDLE.
REQ-033 Tie RR_EN=0, both valid held for 3 ops -> port 0 granted every time; req1_ready never high.
REQ-034 Backpressure: rsp1_ready low 5 cycles (op=8, b=0x80000000, sa=4) -> rsp1_valid held, result 0xF8000000 stable, no new accept until handshake.
REQ-035 Illegal op=15 on req0 -> rsp0_err 1, result 0, zero 1.
REQ-036 rst_n low during RESP -> rsp0_valid low asynchronously; after release, no response, state IDLE.

Source files
------------

// File: rtl/mips_cpu_alu_arbiter.sv
// Two-port front end for one shared MIPS ALU: arbitrates requests, latches the
// winner's operands for the ALU, and holds the captured result until consumed.
module mips_cpu_alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [4:0]  i_req0_op,
  input  logic [31:0] i_req0_a,
  input  logic [31:0] i_req0_b,
  input  logic [4:0]  i_req0_sa,

  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [4:0]  i_req1_op,
  input  logic [31:0] i_req1_a,
  input  logic [31:0] i_req1_b,
  input  logic [4:0]  i_req1_sa,

  output logic        o_rsp0_valid,
  input  logic        i_rsp0_ready,
  output logic [31:0] o_rsp0_result,
  output logic        o_rsp0_zero,
  output logic        o_rsp0_err,

  output logic        o_rsp1_valid,
  input  logic        i_rsp1_ready,
  output logic [31:0] o_rsp1_result,
  output logic        o_rsp1_zero,
  output logic        o_rsp1_err,

  output logic [4:0]  o_alu_op,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [4:0]  o_alu_sa,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_zero
);

  // state  | meaning
  // IDLE   | waiting for a request; only state that raises reqN_ready
  // EXEC   | latched operands on the ALU; result captured at end of cycle
  // RESP   | result presented to the owner until it takes it
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [4:0] OP_MAX = 5'd11;

  state_t      r_state;
  state_t      w_next;

  logic        r_owner;
  logic        r_last_grant;
  logic [4:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_sa;
  logic [31:0] r_result;
  logic        r_zero;
  logic        r_err;

  logic        w_pick0;
  logic        w_pick1;
  logic        w_idle;
  logic        w_accept;
  logic        w_resp;
  logic        w_rsp_fire;

  // Port 1 wins when alone, or on a tie when round-robin says it is its turn.
  assign w_pick1    = i_req1_valid & (~i_req0_valid | (RR_EN & ~r_last_grant));
  assign w_pick0    = i_req0_valid & ~w_pick1;
  assign w_idle     = (r_state == S_IDLE);
  assign w_accept   = w_idle & (w_pick0 | w_pick1);
  assign w_resp     = (r_state == S_RESP);
  assign w_rsp_fire = w_resp & (r_owner ? i_rsp1_ready : i_rsp0_ready);

  // Ready is combinational from the request inputs, so reset must mask it directly.
  assign o_req0_ready = rst_n & w_idle & w_pick0;
  assign o_req1_ready = rst_n & w_idle & w_pick1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (w_rsp_fire) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_op         <= 5'd0;
      r_a          <= 32'd0;
      r_b          <= 32'd0;
      r_sa         <= 5'd0;
      r_result     <= 32'd0;
      r_zero       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner      <= w_pick1;
        r_last_grant <= w_pick1;
        r_op         <= w_pick1 ? i_req1_op : i_req0_op;
        r_a          <= w_pick1 ? i_req1_a  : i_req0_a;
        r_b          <= w_pick1 ? i_req1_b  : i_req0_b;
        r_sa         <= w_pick1 ? i_req1_sa : i_req0_sa;
      end
      if (r_state == S_EXEC) begin
        // Undefined opcodes never trust the ALU: report a clean zero result.
        if (r_op > OP_MAX) begin
          r_err    <= 1'b1;
          r_result <= 32'd0;
          r_zero   <= 1'b1;
        end else begin
          r_err    <= 1'b0;
          r_result <= i_alu_result;
          r_zero   <= i_alu_zero;
        end
      end
    end
  end

  assign o_alu_op = r_op;
  assign o_alu_a  = r_a;
  assign o_alu_b  = r_b;
  assign o_alu_sa = r_sa;

  assign o_rsp0_valid  = w_resp & ~r_owner;
  assign o_rsp0_result = o_rsp0_valid ? r_result : 32'd0;
  assign o_rsp0_zero   = o_rsp0_valid & r_zero;
  assign o_rsp0_err    = o_rsp0_valid & r_err;

  assign o_rsp1_valid  = w_resp & r_owner;
  assign o_rsp1_result = o_rsp1_valid ? r_result : 32'd0;
  assign o_rsp1_zero   = o_rsp1_valid & r_zero;
  assign o_rsp1_err    = o_rsp1_valid & r_err;

endmodule

// File: tb/tb_mips_cpu_alu_arbiter.sv
// Bench for mips_cpu_alu_arbiter: vector table, tie/reset sequences and a
// randomized run against a transaction-level model of arbitration and the ALU.
module tb_mips_cpu_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [4:0]  req0_op, req1_op, req0_sa, req1_sa;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
  logic [4:0]  alu_op, alu_sa;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        alu_zero;

  // Fixed-priority instance: own handshake signals, shared operand buses.
  logic        f_req0_valid, f_req1_valid, f_rsp0_ready, f_rsp1_ready;
  logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid;
  logic [31:0] f_rsp0_result, f_rsp1_result;
  logic        f_rsp0_zero, f_rsp1_zero, f_rsp0_err, f_rsp1_err;
  logic [4:0]  f_alu_op, f_alu_sa;
  logic [31:0] f_alu_a, f_alu_b, f_alu_res;
  logic        f_alu_zero;

  int total = 0;
  int bad = 0;

  // Shared MIPS ALU stand-in; illegal opcodes return junk on purpose.
  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sa);
    case (op)
      5'd0:  return a & b;
      5'd1:  return a | b;
      5'd2:  return a + b;
      5'd3:  return a - b;
      5'd4:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return b << sa;
      5'd7:  return b >> sa;
      5'd8:  return $unsigned($signed(b) >>> sa);
      5'd9:  return b << a[4:0];
      5'd10: return b >> a[4:0];
      5'd11: return $unsigned($signed(b) >>> a[4:0]);
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  assign alu_res    = alu_f(alu_op, alu_a, alu_b, alu_sa);
  assign alu_zero   = (alu_op > 5'd11) ? 1'b0 : (alu_res == 32'd0);
  assign f_alu_res  = alu_f(f_alu_op, f_alu_a, f_alu_b, f_alu_sa);
  assign f_alu_zero = (f_alu_op > 5'd11) ? 1'b0 : (f_alu_res == 32'd0);

  mips_cpu_alu_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_op(req0_op),
    .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_sa(req0_sa),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_op(req1_op),
    .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_sa(req1_sa),
    .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rsp0_ready), .o_rsp0_result(rsp0_result),
    .o_rsp0_zero(rsp0_zero), .o_rsp0_err(rsp0_err),
    .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rsp1_ready), .o_rsp1_result(rsp1_result),
    .o_rsp1_zero(rsp1_zero), .o_rsp1_err(rsp1_err),
    .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_sa(alu_sa),
    .i_alu_result(alu_res), .i_alu_zero(alu_zero)
  );

  mips_cpu_alu_arbiter #(.RR_EN(1'b0)) dut_f (
    .clk(clk), .rst_n(rst_n),
    .i_req0_valid(f_req0_valid), .o_req0_ready(f_req0_ready), .i_req0_op(req0_op),
    .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_sa(req0_sa),
    .i_req1_valid(f_req1_valid), .o_req1_ready(f_req1_ready), .i_req1_op(req1_op),
    .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_sa(req1_sa),
    .o_rsp0_valid(f_rsp0_valid), .i_rsp0_ready(f_rsp0_ready), .o_rsp0_result(f_rsp0_result),
    .o_rsp0_zero(f_rsp0_zero), .o_rsp0_err(f_rsp0_err),
    .o_rsp1_valid(f_rsp1_valid), .i_rsp1_ready(f_rsp1_ready), .o_rsp1_result(f_rsp1_result),
    .o_rsp1_zero(f_rsp1_zero), .o_rsp1_err(f_rsp1_err),
    .o_alu_op(f_alu_op), .o_alu_a(f_alu_a), .o_alu_b(f_alu_b), .o_alu_sa(f_alu_sa),
    .i_alu_result(f_alu_res), .i_alu_zero(f_alu_zero)
  );

  bit f_req1_seen = 1'b0;
  always @(negedge clk) if (f_req1_ready) f_req1_seen = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sa);
    if (p == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_sa = sa;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_sa = sa;
    end
  endtask

  task automatic scramble_reqs();
    set_req(0, 1'($urandom), 5'($urandom), $urandom, $urandom, 5'($urandom));
    set_req(1, 1'($urandom), 5'($urandom), $urandom, $urandom, 5'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
    set_req(1, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    f_req0_valid = 1'b0; f_req1_valid = 1'b0; f_rsp0_ready = 1'b0; f_rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Call with requests already driven, DUT in IDLE, away from the clock edge.
  task automatic step_op(input string tag, input int port, input logic [31:0] er,
                         input logic ez, input logic ee, input int bp, input bit scr);
    logic [31:0] own_res, oth_res;
    logic        own_v, oth_v, own_z, own_e, oth_z, oth_e;
    #1;
    chk({tag, " req0_ready idle"}, 32'(req0_ready), 32'(port == 0));
    chk({tag, " req1_ready idle"}, 32'(req1_ready), 32'(port == 1));
    @(posedge clk); #1;
    if (scr) scramble_reqs();
    #1;
    chk({tag, " ready in exec"}, {30'd0, req1_ready, req0_ready}, 32'd0);
    chk({tag, " rsp valid in exec"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k <= bp; k++) begin
      if (port == 0) begin
        own_v = rsp0_valid; own_res = rsp0_result; own_z = rsp0_zero; own_e = rsp0_err;
        oth_v = rsp1_valid; oth_res = rsp1_result; oth_z = rsp1_zero; oth_e = rsp1_err;
      end else begin
        own_v = rsp1_valid; own_res = rsp1_result; own_z = rsp1_zero; own_e = rsp1_err;
        oth_v = rsp0_valid; oth_res = rsp0_result; oth_z = rsp0_zero; oth_e = rsp0_err;
      end
      chk({tag, " rsp valid owner"}, 32'(own_v), 32'd1);
      chk({tag, " rsp result"}, own_res, er);
      chk({tag, " rsp zero/err"}, {30'd0, own_z, own_e}, {30'd0, ez, ee});
      chk({tag, " non-owner rsp"}, {oth_res[29:0], oth_v, oth_z | oth_e}, 32'd0);
      chk({tag, " ready in resp"}, {30'd0, req1_ready, req0_ready}, 32'd0);
      if (port == 0) begin rsp0_ready = (k == bp); rsp1_ready = 1'($urandom); end
      else           begin rsp1_ready = (k == bp); rsp0_ready = 1'($urandom); end
      @(posedge clk); #1;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    end
    chk({tag, " rsp valid after handshake"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
  endtask

  typedef struct {
    int          port;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [4:0]  sa;
    logic [31:0] exp_res;
    logic        exp_zero, exp_err;
    int          bp;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          last_w;
    int          win, pat;
    logic [4:0]  op0, op1, wop;
    logic [31:0] a0, b0, a1, b1, wa, wb, er;
    logic [4:0]  s0, s1, wsa;

    vecs.push_back('{0, 5'd2,  32'd5,        32'd7,        5'd0,  32'd12,        1'b0, 1'b0, 0});
    vecs.push_back('{1, 5'd3,  32'd9,        32'd9,        5'd0,  32'd0,         1'b1, 1'b0, 0});
    vecs.push_back('{0, 5'd4,  32'hFFFFFFFF, 32'd1,        5'd0,  32'd1,         1'b0, 1'b0, 1});
    vecs.push_back('{1, 5'd4,  32'd1,        32'hFFFFFFFF, 5'd0,  32'd0,         1'b1, 1'b0, 0});
    vecs.push_back('{1, 5'd8,  32'd0,        32'h80000000, 5'd4,  32'hF8000000,  1'b0, 1'b0, 5});
    vecs.push_back('{0, 5'd7,  32'd0,        32'h80000000, 5'd4,  32'h08000000,  1'b0, 1'b0, 0});
    vecs.push_back('{0, 5'd6,  32'd0,        32'd1,        5'd31, 32'h80000000,  1'b0, 1'b0, 2});
    vecs.push_back('{1, 5'd11, 32'h24,       32'h80000000, 5'd0,  32'hF8000000,  1'b0, 1'b0, 0});
    vecs.push_back('{0, 5'd10, 32'd3,        32'hF0,       5'd9,  32'h1E,        1'b0, 1'b0, 0});
    vecs.push_back('{0, 5'd9,  32'd8,        32'd1,        5'd0,  32'h100,       1'b0, 1'b0, 0});
    vecs.push_back('{0, 5'd5,  32'hF0F0,     32'hFF00,     5'd0,  32'h0FF0,      1'b0, 1'b0, 0});
    vecs.push_back('{0, 5'd0,  32'hF0,       32'h0F,       5'd0,  32'd0,         1'b1, 1'b0, 0});
    vecs.push_back('{1, 5'd1,  32'hF0,       32'h0F,       5'd0,  32'hFF,        1'b0, 1'b0, 0});
    vecs.push_back('{0, 5'd15, 32'd1,        32'd2,        5'd0,  32'd0,         1'b1, 1'b1, 0});
    vecs.push_back('{1, 5'd12, 32'd0,        32'd0,        5'd0,  32'd0,         1'b1, 1'b1, 1});

    // Reset values, with requests asserted to show reset masks ready.
    rst_n = 1'b0;
    set_req(0, 1'b1, 5'd2, 32'd1, 32'd1, 5'd1);
    set_req(1, 1'b1, 5'd3, 32'd2, 32'd2, 5'd2);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    f_req0_valid = 1'b1; f_req1_valid = 1'b1; f_rsp0_ready = 1'b0; f_rsp1_ready = 1'b0;
    #23;
    chk("reset ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("reset rsp valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("reset rsp outputs", rsp0_result | rsp1_result |
        32'({rsp0_zero, rsp1_zero, rsp0_err, rsp1_err}), 32'd0);
    chk("reset alu op/sa", {22'd0, alu_op, alu_sa}, 32'd0);
    chk("reset alu a|b", alu_a | alu_b, 32'd0);
    do_reset();

    // Vector table; the first row doubles as the basic single-op case.
    foreach (vecs[i]) begin
      set_req(vecs[i].port, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sa);
      step_op($sformatf("vec%0d", i), vecs[i].port, vecs[i].exp_res,
              vecs[i].exp_zero, vecs[i].exp_err, vecs[i].bp, 1'b0);
      set_req(vecs[i].port, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
    end

    // Round-robin tie right after reset: port 0 first, then port 1.
    do_reset();
    set_req(0, 1'b1, 5'd3, 32'd9, 32'd9, 5'd0);
    set_req(1, 1'b1, 5'd0, 32'h0F, 32'h03, 5'd0);
    step_op("rr tie first", 0, 32'd0, 1'b1, 1'b0, 0, 1'b0);
    step_op("rr tie second", 1, 32'h3, 1'b0, 1'b0, 0, 1'b0);
    step_op("rr tie third", 0, 32'd0, 1'b1, 1'b0, 0, 1'b0);
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
    set_req(1, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);

    // Fixed priority: both held valid for three operations.
    do_reset();
    set_req(0, 1'b0, 5'd2, 32'd1, 32'd1, 5'd0);
    set_req(1, 1'b0, 5'd1, 32'd6, 32'd1, 5'd0);
    f_req1_seen = 1'b0;
    f_req0_valid = 1'b1; f_req1_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("fixed req0_ready", 32'(f_req0_ready), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("fixed rsp0", {f_rsp0_result[29:0], f_rsp0_valid, f_rsp1_valid}, {30'd2, 1'b1, 1'b0});
      f_rsp0_ready = 1'b1;
      @(posedge clk); #1;
      f_rsp0_ready = 1'b0;
    end
    f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    chk("fixed req1_ready never", 32'(f_req1_seen), 32'd0);

    // Randomized traffic vs. transaction model.
    do_reset();
    last_w = 1;
    for (int it = 0; it < 60; it++) begin
      pat = int'($urandom_range(1, 3));
      op0 = 5'($urandom_range(0, 13)); a0 = $urandom; b0 = $urandom; s0 = 5'($urandom);
      op1 = 5'($urandom_range(0, 13)); a1 = $urandom; b1 = $urandom; s1 = 5'($urandom);
      if (it % 7 == 0) begin b0 = a0; b1 = a1; op0 = 5'd3; op1 = 5'd5; end
      set_req(0, pat[0], op0, a0, b0, s0);
      set_req(1, pat[1], op1, a1, b1, s1);
      win = (pat == 3) ? 1 - last_w : (pat == 2 ? 1 : 0);
      last_w = win;
      wop = win ? op1 : op0; wa = win ? a1 : a0; wb = win ? b1 : b0; wsa = win ? s1 : s0;
      if (wop > 5'd11) step_op($sformatf("rand%0d", it), win, 32'd0, 1'b1, 1'b1,
                               int'($urandom_range(0, 3)), 1'b1);
      else begin
        er = alu_f(wop, wa, wb, wsa);
        step_op($sformatf("rand%0d", it), win, er, er == 32'd0, 1'b0,
                int'($urandom_range(0, 3)), 1'b1);
      end
      set_req(0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
      set_req(1, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
    end

    // Reset during RESP drops the response at once and for good.
    do_reset();
    set_req(0, 1'b1, 5'd2, 32'd5, 32'd7, 5'd0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
    @(posedge clk); #1;
    chk("pre-reset rsp0_valid", 32'(rsp0_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("async reset alu_a/b", alu_a | alu_b, 32'd0);
    set_req(0, 1'b1, 5'd2, 32'd1, 32'd1, 5'd0);
    #1;
    chk("ready masked in reset", 32'(req0_ready), 32'd0);
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("no rsp after reset", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end

    // Reset during EXEC, then first accept on the first edge after release.
    set_req(0, 1'b1, 5'd2, 32'd5, 32'd7, 5'd0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
    rst_n = 1'b0;
    #3;
    set_req(1, 1'b1, 5'd2, 32'd1, 32'd2, 5'd0);
    @(negedge clk) rst_n = 1'b1;
    step_op("post-reset accept", 1, 32'd3, 1'b0, 1'b0, 0, 1'b0);
    set_req(1, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
